// File: rtl/bldcm_udiv_seq_pkg.sv
// rtl/bldcm_udiv_seq_pkg.sv - shared state type and sizing helpers for the sequential divider
package mBldcm_DivPkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Widest quotient supported; the top slices the all-ones default down to its own width.
    localparam int unsigned QUOT_MAX_WIDTH = 64;
    localparam logic [QUOT_MAX_WIDTH-1:0] QUOT_ALL_ONES = '1;

    function automatic int step_cnt_width(input int width_numer, input int bits_per_cycle);
        return $clog2(width_numer / bits_per_cycle + 1);
    endfunction

endpackage

// File: rtl/bldcm_div_step.sv
// rtl/bldcm_div_step.sv - combinational restoring-subtract chain resolving pBitsPerCycle quotient bits
module bldcm_div_step #(
    parameter int pWidthDenom   = 16,
    parameter int pBitsPerCycle = 1
) (
    input  logic [pWidthDenom-1:0]   part_rem,
    input  logic [pWidthDenom-1:0]   divisor,
    input  logic [pBitsPerCycle-1:0] numer_bits,
    output logic [pWidthDenom-1:0]   next_rem,
    output logic [pBitsPerCycle-1:0] quot_bits
);

    always_comb begin
        logic [pWidthDenom:0]   trial;
        logic [pWidthDenom-1:0] rem_work;
        trial     = '0;
        rem_work  = part_rem;
        quot_bits = '0;
        // Most significant numerator bit is consumed first.
        for (int i = pBitsPerCycle - 1; i >= 0; i--) begin
            trial = {rem_work, numer_bits[i]};
            if (trial >= {1'b0, divisor}) begin
                trial        = trial - {1'b0, divisor};
                quot_bits[i] = 1'b1;
            end
            rem_work = trial[pWidthDenom-1:0];
        end
        next_rem = rem_work;
    end

endmodule

// File: rtl/bldcm_udiv_seq.sv
// rtl/bldcm_udiv_seq.sv - multi-cycle divider with valid/ready handshakes; BLDCM_DIV_SIGNED_EN enables signed mode
module bldcm_udiv_seq
    import mBldcm_DivPkg::*;
#(
    parameter int pWidthNumer   = 32,
    parameter int pWidthDenom   = 16,
    parameter int pBitsPerCycle = 1
) (
    input  logic                   iClock,
    input  logic                   iReset,
    input  logic                   iValid,
    output logic                   oReady,
    input  logic [pWidthNumer-1:0] iNumer,
    input  logic [pWidthDenom-1:0] iDenom,
    input  logic                   iSigned,
    output logic                   oValid,
    input  logic                   iReady,
    output logic [pWidthNumer-1:0] oQuotient,
    output logic [pWidthDenom-1:0] oRemain,
    output logic                   oDivZero
);

    localparam int NUM_STEPS = pWidthNumer / pBitsPerCycle;
    localparam int CNT_WIDTH = step_cnt_width(pWidthNumer, pBitsPerCycle);
    localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(NUM_STEPS - 1);

    div_state_t state, state_nxt;

    // Numerator shifts out of the top while quotient bits shift in at the bottom.
    logic [pWidthNumer-1:0]   quot;
    logic [pWidthDenom-1:0]   part_rem;
    logic [pWidthDenom-1:0]   divisor;
    logic [CNT_WIDTH-1:0]     step_cnt;
    logic                     div_zero;
    logic                     accept;
    logic                     last_step;
    logic [pWidthNumer-1:0]   numer_mag;
    logic [pWidthDenom-1:0]   denom_mag;
    logic [pWidthDenom-1:0]   next_rem;
    logic [pBitsPerCycle-1:0] quot_bits;

`ifdef BLDCM_DIV_SIGNED_EN
    logic numer_neg;
    logic denom_neg;
    logic neg_quot;
    logic neg_rem;

    assign numer_neg = iSigned & iNumer[pWidthNumer-1];
    assign denom_neg = iSigned & iDenom[pWidthDenom-1];
    assign numer_mag = numer_neg ? -iNumer : iNumer;
    assign denom_mag = denom_neg ? -iDenom : iDenom;

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (accept) begin
            neg_quot <= numer_neg ^ denom_neg;
            neg_rem  <= numer_neg;
        end
    end
`else
    logic unused_signed;
    assign unused_signed = iSigned;
    assign numer_mag     = iNumer;
    assign denom_mag     = iDenom;
`endif

    bldcm_div_step #(
        .pWidthDenom  (pWidthDenom),
        .pBitsPerCycle(pBitsPerCycle)
    ) u_step (
        .part_rem  (part_rem),
        .divisor   (divisor),
        .numer_bits(quot[pWidthNumer-1 -: pBitsPerCycle]),
        .next_rem  (next_rem),
        .quot_bits (quot_bits)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_step = (step_cnt == LAST_STEP);
        case (state)
            IDLE: begin
                if (iValid) begin
                    accept    = 1'b1;
                    state_nxt = (iDenom == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
`ifdef BLDCM_DIV_SIGNED_EN
                    state_nxt = FIX;
`else
                    state_nxt = DONE;
`endif
                end
            end
            FIX:     state_nxt = DONE;
            DONE:    if (iReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state    <= IDLE;
            quot     <= '0;
            part_rem <= '0;
            divisor  <= '0;
            step_cnt <= '0;
            div_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        step_cnt <= '0;
                        if (iDenom == '0) begin
                            quot     <= QUOT_ALL_ONES[pWidthNumer-1:0];
                            part_rem <= iNumer[pWidthDenom-1:0];
                            div_zero <= 1'b1;
                        end else begin
                            quot     <= numer_mag;
                            part_rem <= '0;
                            divisor  <= denom_mag;
                            div_zero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    quot     <= {quot[pWidthNumer-pBitsPerCycle-1:0], quot_bits};
                    part_rem <= next_rem;
                    step_cnt <= step_cnt + CNT_WIDTH'(1);
                end
`ifdef BLDCM_DIV_SIGNED_EN
                FIX: begin
                    if (neg_quot) quot <= -quot;
                    if (neg_rem)  part_rem <= -part_rem;
                end
`endif
                default: ;
            endcase
        end
    end

    assign oReady    = (state == IDLE);
    assign oValid    = (state == DONE);
    assign oQuotient = quot;
    assign oRemain   = part_rem;
    assign oDivZero  = div_zero;

endmodule

// File: doc/bldcm_udiv_seq.md
Name: bldcm_udiv_seq

Overview:
- Parametrised multi-cycle integer divider with valid/ready handshakes on input and output.
- Successor to the fixed-pipeline vendor-LPM divider wrapper: vendor-independent RTL, configurable bits retired per cycle, and an explicit divide-by-zero flag.
- Remainder is sized to the denominator, not the numerator.
- Used by the BLDC speed/period computation path, e.g. commutation period to RPM, where throughput need is low and area matters.

Parameters:
- pWidthNumer, 32, numerator and quotient width; must be a multiple of pBitsPerCycle.
- pWidthDenom, 16, denominator and remainder width; must be ≤ pWidthNumer.
- pBitsPerCycle, 1, quotient bits resolved per CALC cycle. Legal values: 1, 2, 4.

Ports:
- iClock  in  1  clock.
- iReset  in  1  synchronous active-high reset.
- iValid  in  1  operand valid.
- oReady  out  1  block can accept operands.
- iNumer  in  pWidthNumer  dividend.
- iDenom  in  pWidthDenom  divisor.
- iSigned  in  1  signed-mode request; functional only with the optional feature.
- oValid  out  1  result valid.
- iReady  in  1  downstream accepts result.
- oQuotient  out  pWidthNumer  quotient.
- oRemain  out  pWidthDenom  remainder.
- oDivZero  out  1  result came from iDenom == 0.

Behaviour:
- Reset (synchronous, iReset=1 at a rising edge of iClock):
  - State goes to IDLE.
  - oValid=0, oQuotient=0, oRemain=0, oDivZero=0; oReady=1 in the cycle after reset.
  - Reset mid-operation aborts the divide with no output.
- Input handshake:
  - Operands are accepted on a cycle where iValid && oReady.
  - oReady=1 only in IDLE.
  - iNumer and iDenom are captured into internal registers at acceptance. Input changes after acceptance have no effect.
- Output handshake:
  - In DONE, oValid=1; oQuotient, oRemain and oDivZero are stable until iValid... no: until iReady=1.
  - Transfer occurs on oValid && iReady; the next state is IDLE.
  - oReady stays 0 during DONE, so there is no same-cycle accept. Throughput is one operation per latency + 1 cycles minimum.
- States:
  - IDLE: wait for accept, then go to CALC, or to DONE when the captured denominator is 0.
  - CALC: restoring division. Each cycle shifts pBitsPerCycle numerator bits into the partial remainder (width pWidthDenom+1 per step) and does pBitsPerCycle trial subtracts chained combinationally. A step counter counts N = pWidthNumer/pBitsPerCycle cycles, then goes to DONE.
  - DONE: hold result until the output handshake.
- Latency: accept edge to oValid=1 is N+1 cycles (e.g. 33 for defaults). Divide-by-zero latency is 1 cycle.
- Divide by zero: oQuotient = all ones, oRemain = iNumer[pWidthDenom-1:0], oDivZero=1.
- Arithmetic:
  - Unsigned. Quotient = floor(N/D); remainder = N − Q·D, always < D, so it fits pWidthDenom.
  - No overflow is possible in unsigned mode.
- Simultaneous events:
  - iReset dominates everything.
  - oValid=0 whenever not in DONE.
  - iReady is ignored outside DONE.

Optional Feature:
- Macro: BLDCM_DIV_SIGNED_EN.
- Defined:
  - iSigned is sampled at accept. When iSigned=1, operands are two's complement.
  - Magnitudes are divided unsigned, then the result is corrected: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Sign fix-up costs 1 extra cycle (a FIX state between CALC and DONE), so latency is N+2.
  - Divide by zero behaves as in unsigned mode.
  - Most-negative ÷ −1: quotient = most-negative value, remainder = 0, oDivZero=0.
- Undefined: iSigned is ignored (integrators tie it to 0); no FIX state; latency is always N+1.

Decomposition:
- Shared package mBldcm_DivPkg:
  - State enum IDLE/CALC/FIX/DONE.
  - Function for the step-counter width: clog2(pWidthNumer/pBitsPerCycle + 1).
  - Localparam for the all-ones quotient default.
- One sub-module bldcm_div_step: combinational pBitsPerCycle-deep restoring subtract chain. Inputs are partial remainder, divisor and numerator bits; outputs are the next partial remainder and the quotient bits.
- FSM, counter and handshake stay in the top module.

Test Plan:
- Defaults, N=1000, D=7, iReady held 1 → oValid exactly 33 cycles after accept; Q=142, R=6, oDivZero=0; oReady returns next cycle.
- N=0xFFFFFFFF, D=0xFFFF, pBitsPerCycle=4 → latency 9; Q=0x00010001, R=0.
- D=0, N=0x12345678 → oValid 1 cycle after accept; Q=0xFFFFFFFF, R=0x5678, oDivZero=1.
- Backpressure: iReady=0 for 10 cycles in DONE → outputs stable, oReady=0, a second iValid is not accepted; it is accepted once the result transfers.
- iReset pulsed at CALC cycle 5 → next cycle oValid=0, oReady=1; a fresh N=100, D=10 then yields Q=10, R=0.
- With BLDCM_DIV_SIGNED_EN, iSigned=1, N=−7, D=2 → Q=−3, R=−1, latency 34. Also 0x80000000 ÷ 0xFFFF (−1) → Q=0x80000000, R=0.
